fitness_sequencer: RTL and testbench

// - Sequences one gene block evaluation over every primary-input vector and scores the result against a target truth table.
// - Sits between the GA controller and geneBlock.
// - Per vector: overwrites the gene's primary-input field, pulses geneIsReady, waits for blockResultIsReady,

---
 rtl/fitness_sequencer_pkg.sv | 26 ++
 rtl/fitness_sequencer_match_counter.sv | 21 ++
 rtl/fitness_sequencer.sv | 151 +++++++++++++++
 tb/tb_fitness_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_sequencer_pkg.sv
// Shared definitions for the fitness sequencer: geneBlock control code, FSM state
// encoding and a ceil-log2 helper used to size counters.
package fitness_sequencer_pkg;

  localparam logic [2:0] FITNESS_CONTROLLER = 3'b001;
  localparam int         PI_BIT_DEFAULT     = 3;
  localparam int         NV_DEFAULT         = 2 ** PI_BIT_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_APPLY = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } fsm_state_e;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fitness_sequencer_match_counter.sv
// Combinational scorer: counts the bits where a geneBlock result agrees with its target.
module match_counter #(
  parameter int resultBit = 2,
  parameter int countBit  = 2
) (
  input  logic [resultBit-1:0] result_i,
  input  logic [resultBit-1:0] target_i,
  output logic [countBit-1:0]  matchCount_o
);

  logic [resultBit-1:0] same;

  always_comb begin
    same         = ~(result_i ^ target_i);
    matchCount_o = '0;
    for (int i = 0; i < resultBit; i++) begin
      matchCount_o = matchCount_o + countBit'(same[i]);
    end
  end

endmodule

// File: rtl/fitness_sequencer.sv
// Drives one gene through geneBlock for every primary-input vector and accumulates
// the number of result bits that match the target truth table.
module fitness_sequencer
  import fitness_sequencer_pkg::*;
#(
  parameter int         geneBit            = 107,
  parameter int         primaryInputBit    = PI_BIT_DEFAULT,
  parameter int         resultBit          = 2,
  parameter int         fitBit             = 5,
  parameter int         timeoutCycles      = 64,
  parameter logic [2:0] fitness_controller = FITNESS_CONTROLLER
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [geneBit-1:0]                         geneIn,
  input  logic [(2**primaryInputBit)*resultBit-1:0]  targetTable,
  input  logic [resultBit-1:0]                       blockResult,
  input  logic                                       blockResultIsReady,
  output logic [geneBit-1:0]                         geneOut,
  output logic                                       geneIsReady,
  output logic [2:0]                                 state_controller,
  output logic [fitBit-1:0]                          fitness,
  output logic                                       fitnessValid,
  output logic                                       timeoutErr,
  output logic                                       busy
);

  localparam int NV      = 2 ** primaryInputBit;
  localparam int VEC_W   = primaryInputBit + 1;
  localparam int WAIT_W  = clog2(timeoutCycles);
  localparam int SETUP_W = clog2(primaryInputBit + 3);
  localparam int CNT_W   = clog2(resultBit + 1);
  localparam int LOW_W   = geneBit - primaryInputBit;

  fsm_state_e         state_q, state_d;
  logic [LOW_W-1:0]   geneReg_q, geneReg_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [SETUP_W-1:0] setupCnt_q, setupCnt_d;
  logic [fitBit-1:0]  acc_q, acc_d;
  logic [fitBit-1:0]  fitness_q, fitness_d;
  logic               timeoutErr_q, timeoutErr_d;

  logic [resultBit-1:0] targetSlice;
  logic [CNT_W-1:0]     matchCount;

  // Only the low field of the gene is stored; the primary-input field is regenerated from vec.
  assign targetSlice = targetTable[vec_q[primaryInputBit-1:0]*resultBit +: resultBit];

  match_counter #(
    .resultBit (resultBit),
    .countBit  (CNT_W)
  ) u_match (
    .result_i     (blockResult),
    .target_i     (targetSlice),
    .matchCount_o (matchCount)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      geneReg_q    <= '0;
      vec_q        <= '0;
      waitCnt_q    <= '0;
      setupCnt_q   <= '0;
      acc_q        <= '0;
      fitness_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      geneReg_q    <= geneReg_d;
      vec_q        <= vec_d;
      waitCnt_q    <= waitCnt_d;
      setupCnt_q   <= setupCnt_d;
      acc_q        <= acc_d;
      fitness_q    <= fitness_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    geneReg_d    = geneReg_q;
    vec_d        = vec_q;
    waitCnt_d    = waitCnt_q;
    setupCnt_d   = setupCnt_q;
    acc_d        = acc_q;
    fitness_d    = fitness_q;
    timeoutErr_d = timeoutErr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          geneReg_d    = geneIn[LOW_W-1:0];
          vec_d        = '0;
          acc_d        = '0;
          fitness_d    = '0;
          timeoutErr_d = 1'b0;
          setupCnt_d   = '0;
          state_d      = ST_SETUP;
        end
      end
      // geneBlock needs primaryInputBit+2 cycles to settle its column offsets.
      ST_SETUP: begin
        if (setupCnt_q == SETUP_W'(primaryInputBit + 1)) begin
          state_d = ST_APPLY;
        end else begin
          setupCnt_d = setupCnt_q + SETUP_W'(1);
        end
      end
      ST_APPLY: begin
        waitCnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (blockResultIsReady) begin
          acc_d   = acc_q + fitBit'(matchCount);
          state_d = ST_NEXT;
        end else if (waitCnt_q == WAIT_W'(timeoutCycles - 1)) begin
          timeoutErr_d = 1'b1;
          fitness_d    = acc_q;
          state_d      = ST_ABORT;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      ST_NEXT: begin
        if (vec_q == VEC_W'(NV - 1)) begin
          fitness_d = acc_q;
          state_d   = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = ST_APPLY;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign geneOut          = {vec_q[primaryInputBit-1:0], geneReg_q};
  assign geneIsReady      = (state_q == ST_APPLY);
  assign fitnessValid     = (state_q == ST_DONE);
  assign busy             = (state_q != ST_IDLE);
  assign state_controller = busy ? fitness_controller : 3'b000;
  assign fitness          = fitness_q;
  assign timeoutErr       = timeoutErr_q;

endmodule

// File: tb/tb_fitness_sequencer.sv
// Directed bench for fitness_sequencer with a behavioural geneBlock that answers
// 4 cycles after each launch (or never, or holds ready high, per modelMode).
module tb_fitness_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [106:0] geneIn = '0;
  logic [15:0]  targetTable = '0;
  logic [1:0]   blockResult;
  logic         blockResultIsReady;
  logic [106:0] geneOut;
  logic         geneIsReady;
  logic [2:0]   state_controller;
  logic [4:0]   fitness;
  logic         fitnessValid;
  logic         timeoutErr;
  logic         busy;

  int passCount = 0;
  int checkCount = 0;

  fitness_sequencer #(
    .geneBit(107), .primaryInputBit(3), .resultBit(2), .fitBit(5), .timeoutCycles(64)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .geneIn             (geneIn),
    .targetTable        (targetTable),
    .blockResult        (blockResult),
    .blockResultIsReady (blockResultIsReady),
    .geneOut            (geneOut),
    .geneIsReady        (geneIsReady),
    .state_controller   (state_controller),
    .fitness            (fitness),
    .fitnessValid       (fitnessValid),
    .timeoutErr         (timeoutErr),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // modelMode: 0 = answer after 4 cycles, 1 = never answer, 2 = ready held high
  int         modelMode = 0;
  logic [3:0] readyPipe;
  logic [7:0] resPipe;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      readyPipe <= '0;
      resPipe   <= '0;
    end else begin
      readyPipe <= {readyPipe[2:0], geneIsReady && (modelMode == 0)};
      resPipe   <= {resPipe[5:0], geneOut[105:104]};
    end
  end

  assign blockResultIsReady = (modelMode == 2) ? 1'b1 : readyPipe[3];
  assign blockResult        = (modelMode == 2) ? geneOut[105:104] : resPipe[7:6];

  int           cycleCnt = 0;
  int           launchTotal = 0;
  int           validTotal = 0;
  int           lowBad = 0;
  int           lastValidCycle = 0;
  logic [2:0]   launchLog [256];
  logic [103:0] expectedLow = '0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  always @(negedge clk) begin
    if (geneIsReady === 1'b1) begin
      if (launchTotal < 256) launchLog[launchTotal] = geneOut[106:104];
      if (geneOut[103:0] !== expectedLow) lowBad++;
      launchTotal++;
    end
    if (fitnessValid === 1'b1) begin
      validTotal++;
      lastValidCycle = cycleCnt;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  int startCycle = 0;

  task automatic applyStimulus(input logic [106:0] gene, input logic [15:0] tbl);
    geneIn      = gene;
    targetTable = tbl;
    expectedLow = gene[103:0];
    start       = 1'b1;
    startCycle  = cycleCnt;
    tick();
    start = 1'b0;
  endtask

  task automatic waitValid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (fitnessValid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitIdle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkLaunchOrder(input string tag, input int base);
    logic [23:0] obs;
    logic [23:0] exp;
    for (int i = 0; i < 8; i++) begin
      obs[i*3 +: 3] = launchLog[base + i];
      exp[i*3 +: 3] = i[2:0];
    end
    checkOutput(tag, obs, exp);
  endtask

  logic [106:0] g1, g2, g3;
  logic [15:0]  identityTbl, invTbl, offTbl;
  int           baseLaunch, baseValid, baseLow;
  bit           ok;

  initial begin
    g1 = {11'h5A3, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
    g2 = {11'h7FF, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'h3C3C3C3C};
    g3 = {11'h2C1, 32'h13579BDF, 32'h2468ACE0, 32'h89ABCDEF};
    for (int v = 0; v < 8; v++) identityTbl[v*2 +: 2] = v[1:0];
    invTbl = ~identityTbl;
    offTbl = identityTbl ^ {8{2'b01}};

    // reset state
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_geneOut", geneOut, 0);
    checkOutput("rst_fitness", fitness, 0);
    checkOutput("rst_valid", fitnessValid, 0);
    checkOutput("rst_geneIsReady", geneIsReady, 0);
    checkOutput("rst_timeoutErr", timeoutErr, 0);
    checkOutput("rst_stateCtrl", state_controller, 0);
    rst = 1'b1;
    tick();

    // identity table, geneIn changed after acceptance
    baseLaunch = launchTotal; baseValid = validTotal; baseLow = lowBad;
    applyStimulus(g1, identityTbl);
    geneIn = ~g1;
    checkOutput("A_busy", busy, 1);
    checkOutput("A_stateCtrl", state_controller, 3'b001);
    checkOutput("A_setupNoLaunch", geneIsReady, 0);
    checkOutput("A_geneOutLow", geneOut[103:0], g1[103:0]);
    checkOutput("A_geneOutField", geneOut[106:104], 0);
    waitValid(200, ok);
    checkOutput("A_validSeen", ok, 1);
    checkOutput("A_latency", lastValidCycle - startCycle, 54);
    checkOutput("A_fitness", fitness, 16);
    checkOutput("A_busyInDone", busy, 1);
    tick();
    checkOutput("A_busyAfter", busy, 0);
    checkOutput("A_validPulse", fitnessValid, 0);
    checkOutput("A_fitnessHeld", fitness, 16);
    checkOutput("A_validCount", validTotal - baseValid, 1);
    checkOutput("A_launchCount", launchTotal - baseLaunch, 8);
    checkLaunchOrder("A_launchOrder", baseLaunch);
    checkOutput("A_lowBits", lowBad - baseLow, 0);
    checkOutput("A_timeoutErr", timeoutErr, 0);

    // inverted table; start in the DONE cycle is dropped, then accepted in IDLE
    applyStimulus(g2, invTbl);
    waitValid(200, ok);
    checkOutput("B_validSeen", ok, 1);
    checkOutput("B_fitness", fitness, 0);
    targetTable = offTbl;
    start = 1'b1;
    tick();
    checkOutput("B_startInDoneDropped", busy, 0);
    startCycle = cycleCnt;
    tick();
    checkOutput("C_startAccepted", busy, 1);
    start = 1'b0;
    waitValid(200, ok);
    checkOutput("C_validSeen", ok, 1);
    checkOutput("C_latency", lastValidCycle - startCycle, 54);
    checkOutput("C_fitness", fitness, 8);
    tick();

    // geneBlock never answers
    modelMode = 1;
    baseLaunch = launchTotal; baseValid = validTotal;
    applyStimulus(g3, identityTbl);
    waitIdle(300, ok);
    checkOutput("D_idleSeen", ok, 1);
    checkOutput("D_abortTiming", cycleCnt - startCycle, 72);
    checkOutput("D_timeoutErr", timeoutErr, 1);
    checkOutput("D_fitness", fitness, 0);
    checkOutput("D_noValid", validTotal - baseValid, 0);
    checkOutput("D_launchCount", launchTotal - baseLaunch, 1);
    checkOutput("D_stateCtrl", state_controller, 0);
    tick();
    checkOutput("D_errSticky", timeoutErr, 1);
    modelMode = 0;
    applyStimulus(g3, identityTbl);
    checkOutput("D_errCleared", timeoutErr, 0);
    waitValid(200, ok);
    checkOutput("D_validSeen", ok, 1);
    checkOutput("D_fitnessAfter", fitness, 16);
    tick();

    // ready held high, start pulsed mid-run
    modelMode = 2;
    baseLaunch = launchTotal; baseValid = validTotal; baseLow = lowBad;
    applyStimulus(g1, identityTbl);
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitValid(200, ok);
    checkOutput("E_validSeen", ok, 1);
    checkOutput("E_latency", lastValidCycle - startCycle, 30);
    checkOutput("E_fitness", fitness, 16);
    repeat (2) tick();
    checkOutput("E_noRestart", busy, 0);
    checkOutput("E_validCount", validTotal - baseValid, 1);
    checkOutput("E_launchCount", launchTotal - baseLaunch, 8);
    checkLaunchOrder("E_launchOrder", baseLaunch);
    checkOutput("E_lowBits", lowBad - baseLow, 0);

    // reset during vector 5, then a fresh full run
    modelMode = 0;
    baseLaunch = launchTotal; baseValid = validTotal;
    applyStimulus(g2, identityTbl);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (launchTotal - baseLaunch >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("F_vector5Reached", ok, 1);
    rst = 1'b0;
    #1;
    checkOutput("F_busy", busy, 0);
    checkOutput("F_geneOut", geneOut, 0);
    checkOutput("F_fitness", fitness, 0);
    checkOutput("F_geneIsReady", geneIsReady, 0);
    checkOutput("F_stateCtrl", state_controller, 0);
    checkOutput("F_timeoutErr", timeoutErr, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkOutput("F_noValid", validTotal - baseValid, 0);
    baseValid = validTotal;
    applyStimulus(g1, identityTbl);
    waitValid(200, ok);
    checkOutput("F_validSeen", ok, 1);
    checkOutput("F_fitness16", fitness, 16);
    tick();
    checkOutput("F_validCount", validTotal - baseValid, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
